load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-access stage directly downstream of the ALU in the multicycle RV32I core.
//  Takes the ALU-computed effective address, the store data (rs2) and funct3 and runs one
//  load or store on a word-wide req/ack data-memory port.
//  Handles byte-lane steering, write strobes, load sign/zero extension, misalignment and
//  illegal-funct3 detection, and a bus timeout. Returns a result for register writeback.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles mem_req stays high without mem_ack; 0 disables timeout
// PORTS
//  clk         in   1   clock; all state changes on posedge
//  resetn      in   1   asynchronous active-low reset
//  req_valid   in   1   core requests an access; sampled only while req_ready=1
//  req_ready   out  1   LSU idle and accepting
//  req_store   in   1   1=store, 0=load
//  req_funct3  in   3   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr    in   32  effective address (ALU result)
//  req_wdata   in   32  store data (rs2)
//  resp_valid  out  1   one-cycle pulse: access complete
//  resp_rdata  out  32  extended load data; 0 for stores and on error
//  resp_err    out  2   00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
//  mem_req     out  1   memory request, held until mem_ack or timeout
//  mem_we      out  1   1=write
//  mem_addr    out  32  word address {addr[31:2],2'b00}
//  mem_wdata   out  32  lane-replicated store data
//  mem_wstrb   out  4   byte enables; 0000 on reads
//  mem_ack     in   1   memory done; sampled only while mem_req=1
//  mem_rdata   in   32  read word, valid in the cycle mem_ack=1
// BEHAVIOUR
//  Reset: async, immediate. State IDLE. All outputs 0 except req_ready=1.
//    An in-flight mem_req drops at once and the pending access is abandoned.
//  FSM states: IDLE, MEM, RESP.
//  IDLE: req_ready=1. On req_valid at edge E0, latch store/funct3/addr/wdata and check legality.
//    Legal load funct3: 000,001,010,100,101. Legal store funct3: 000,001,010.
//    Illegal funct3 -> RESP with err=10.
//    Else if misaligned (H: addr[0]!=0; W: addr[1:0]!=0) -> RESP with err=01.
//    Otherwise -> MEM. Illegal is checked before misaligned.
//    Error paths never assert mem_req.
//  MEM: mem_req=1. mem_we/addr/wdata/wstrb stay stable until exit. Timeout counter clears on entry.
//    mem_ack=1 at edge E1 -> capture mem_rdata, drop mem_req, go to RESP with err=00.
//    Counter reaches TIMEOUT_CYCLES with no ack -> drop mem_req, go to RESP with err=11.
//    If the ack arrives in the same cycle the limit is reached, the ack wins.
//  RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 throughout MEM and RESP.
//    A req_valid outside IDLE is ignored, not queued.
//  Latency: zero-wait ack gives resp_valid in the 2nd cycle after acceptance.
//    Error paths give resp_valid in the 1st cycle after acceptance.
//    Minimum issue interval is 3 cycles.
//  Store steering, with b=addr[1:0]:
//    SB: wstrb=0001<<b, wdata={4{wdata[7:0]}}
//    SH: wstrb=addr[1]?1100:0011, wdata={2{wdata[15:0]}}
//    SW: wstrb=1111, wdata unchanged
//  Load extract: word>>(8*b), then LB/LH sign-extend and LBU/LHU zero-extend.
//  resp_rdata/resp_err hold their value outside RESP until the next RESP. They are 0 after reset.
//  mem_ack while mem_req=0 is ignored.
// TESTING
//  LW addr=0x100, mem_rdata=0xDEADBEEF, ack in 1st MEM cycle -> mem_addr=0x100, wstrb=0000, resp_rdata=0xDEADBEEF, err=00, resp_valid 2 cycles after accept
//  LB addr=0x203, word=0x80123456 -> resp_rdata=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x202 -> 0x00008012
//  SB addr=0x301, wdata=0x000000AB -> mem_wdata=0xABABABAB, wstrb=0010, mem_we=1; SH addr=0x302 -> wstrb=1100; resp_rdata=0
//  LW addr=0x102 -> err=01, no mem_req; store funct3=011 -> err=10; load funct3=011 at addr=0x101 -> err=10
//  TIMEOUT_CYCLES=4, never ack -> mem_req high 4 cycles, then err=11, rdata=0; late ack afterwards ignored
//  resetn low mid-MEM -> mem_req, resp_valid drop same cycle; req_ready=1; next LW completes normally

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-access stage of the multicycle RV32I core: runs one load or store per request on a
// word-wide req/ack data port with lane steering, load extension, error detection and bus timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MEM = 2'd1, ST_RESP = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      maddr_q, maddr_d;
  logic [31:0]      mwdata_q, mwdata_d;
  logic [3:0]       mwstrb_q, mwstrb_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       err_q, err_d;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~store;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_steer(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{w[7:0]}};
      2'b01:   d = {2{w[15:0]}};
      default: d = w;
    endcase
    return d;
  endfunction

  // Right-justify the addressed lane, then extend according to the load width/signedness.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b100:  r = {24'd0, sh[7:0]};
      3'b101:  r = {16'd0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  assign req_ready  = (state_q == ST_IDLE);
  assign mem_req    = (state_q == ST_MEM);
  assign resp_valid = (state_q == ST_RESP);
  assign mem_we     = we_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = mwdata_q;
  assign mem_wstrb  = mwstrb_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Next-state and datapath capture for the IDLE/MEM/RESP sequencer.
  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mwstrb_d = mwstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          f3_d  = req_funct3;
          off_d = req_addr[1:0];
          cnt_d = '0;
          if (!f3_legal(req_store, req_funct3)) begin
            err_d   = ERR_ILLEGAL;
            rdata_d = 32'd0;
            state_d = ST_RESP;
          end else if (f3_misaligned(req_funct3, req_addr[1:0])) begin
            err_d   = ERR_MISALIGN;
            rdata_d = 32'd0;
            state_d = ST_RESP;
          end else begin
            we_d     = req_store;
            maddr_d  = {req_addr[31:2], 2'b00};
            mwdata_d = store_steer(req_funct3, req_wdata);
            mwstrb_d = req_store ? store_strobe(req_funct3, req_addr[1:0]) : 4'b0000;
            state_d  = ST_MEM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEM: begin
        // An ack in the limit cycle still completes normally.
        if (mem_ack) begin
          rdata_d = we_q ? 32'd0 : load_extend(f3_q, off_q, mem_rdata);
          err_d   = ERR_OK;
          state_d = ST_RESP;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          rdata_d = 32'd0;
          err_d   = ERR_TIMEOUT;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      maddr_q  <= 32'd0;
      mwdata_q <= 32'd0;
      mwstrb_q <= 4'd0;
      rdata_q  <= 32'd0;
      err_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwstrb_q <= mwstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed spec cases plus randomized accesses checked
// against an arithmetic reference model and a behavioural word memory.
module tb_load_store_unit;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic [1:0] err; int unsigned lat; } resp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; bit timeout; } memtx_t;

  resp_t       resp_q[$];
  memtx_t      mem_q[$];
  logic [31:0] mem_arr [int unsigned];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int unsigned plan_delay = 0;
  int unsigned rcnt = 0;
  bit          in_mem = 1'b0;
  int unsigned mcyc = 0;
  memtx_t      cur;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_read(input int unsigned widx);
    if (mem_arr.exists(widx)) return mem_arr[widx];
    return (widx * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] load_ref(input logic [2:0] f3, input int unsigned off, input logic [31:0] word);
    logic [31:0] v;
    logic [31:0] b;
    logic [31:0] h;
    v = word >> (8 * off);
    b = v % 256;
    h = v % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return v;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge with req_ready=1: the request is accepted at the next posedge.
  task automatic start(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int unsigned dly);
    resp_t       r;
    memtx_t      m;
    bit          legal, mis;
    int unsigned sz, off;
    sz    = f3 % 4;
    off   = addr % 4;
    legal = st ? (f3 <= 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    mis   = (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
    r.rdata = 32'd0;
    r.lat   = 0;
    if (!legal) r.err = 2'b10;
    else if (mis) r.err = 2'b01;
    else begin
      m.we      = st;
      m.addr    = addr - off;
      m.timeout = (dly >= TO);
      if (!st) begin
        m.wdata = 32'd0;
        m.wstrb = 4'b0000;
      end else if (sz == 0) begin
        m.wdata = (wd % 256) * 32'h01010101;
        m.wstrb = 4'(1 << off);
      end else if (sz == 1) begin
        m.wdata = (wd % 65536) * 32'h00010001;
        m.wstrb = (off == 2) ? 4'b1100 : 4'b0011;
      end else begin
        m.wdata = wd;
        m.wstrb = 4'b1111;
      end
      mem_q.push_back(m);
      if (m.timeout) begin
        r.err = 2'b11;
        r.lat = TO;
      end else begin
        r.err = 2'b00;
        r.lat = dly + 1;
        if (!st) r.rdata = load_ref(f3, off, mem_read(addr / 4));
      end
    end
    resp_q.push_back(r);
    plan_delay = dly;
    acc_cyc    = cyc + 1;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  // Waits for resp_valid while toggling junk requests that must be ignored.
  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        req_valid = 1'b0;
        return;
      end
      req_valid  = 1'($urandom % 2);
      req_store  = 1'($urandom % 2);
      req_funct3 = 3'($urandom % 8);
      req_addr   = $urandom;
    end
    req_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL wait_resp actual=no_resp_valid expected=resp_valid_within_40");
  endtask

  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int unsigned dly);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    start(st, f3, addr, wd, dly);
    wait_done();
  endtask

  // Memory model: acks after the planned delay, emits spurious acks while mem_req is low.
  always @(negedge clk) begin
    if (!resetn || !mem_req) begin
      rcnt      = 0;
      mem_ack   = 1'($urandom % 4 == 0);
      mem_rdata = $urandom;
    end else begin
      if (rcnt == plan_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_read(mem_addr / 4);
        if (mem_we) begin
          logic [31:0] w;
          w = mem_rdata;
          for (int l = 0; l < 4; l++)
            if (mem_wstrb[l]) w[8*l +: 8] = mem_wdata[8*l +: 8];
          mem_arr[mem_addr / 4] = w;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      rcnt++;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (resetn && resp_valid) begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected actual=resp_valid expected=no_resp");
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        chk("resp_rdata", resp_rdata, r.rdata);
        chk("resp_err", 32'(resp_err), 32'(r.err));
        chk("resp_latency", cyc - acc_cyc, r.lat);
      end
    end
  end

  // Memory-side monitor: request contents, stability and timeout duration.
  always @(negedge clk) begin
    if (!resetn) begin
      in_mem = 1'b0;
    end else if (mem_req && !in_mem) begin
      in_mem = 1'b1;
      mcyc   = 1;
      if (mem_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_req_unexpected actual=mem_req expected=no_mem_req");
        cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata; cur.wstrb = mem_wstrb; cur.timeout = 1'b0;
      end else begin
        cur = mem_q.pop_front();
      end
      chk("mem_we", 32'(mem_we), 32'(cur.we));
      chk("mem_addr", mem_addr, cur.addr);
      chk("mem_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
      if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
    end else if (mem_req && in_mem) begin
      mcyc++;
      chk("mem_stable", {mem_addr[31:2], mem_we, mem_wstrb[0]}, {cur.addr[31:2], cur.we, cur.wstrb[0]});
    end else if (!mem_req && in_mem) begin
      in_mem = 1'b0;
      if (cur.timeout) chk("timeout_req_cycles", mcyc, TO);
    end
  end

  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_outputs", {29'd0, mem_req, resp_valid, mem_we}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err_wstrb", {26'd0, resp_err, mem_wstrb}, 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    mem_arr[32'h100 / 4] = 32'hDEADBEEF;
    mem_arr[32'h200 / 4] = 32'h80123456;
    issue(1'b0, 3'b010, 32'h100, 32'h0, 0);
    issue(1'b0, 3'b000, 32'h203, 32'h0, 1);
    issue(1'b0, 3'b100, 32'h203, 32'h0, 2);
    issue(1'b0, 3'b101, 32'h202, 32'h0, 0);
    issue(1'b1, 3'b000, 32'h301, 32'h000000AB, 0);
    issue(1'b1, 3'b001, 32'h302, 32'h1234CDEF, 1);
    issue(1'b0, 3'b010, 32'h102, 32'h0, 0);
    issue(1'b1, 3'b011, 32'h100, 32'h0, 0);
    issue(1'b0, 3'b011, 32'h101, 32'h0, 0);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 255);
    issue(1'b0, 3'b010, 32'h100, 32'h0, TO - 1);

    for (int n = 0; n < 300; n++) begin
      bit          st;
      logic [2:0]  f3;
      int unsigned dly;
      st = 1'($urandom % 2);
      if ($urandom % 8 == 0) f3 = 3'($urandom % 8);
      else if (st) f3 = 3'($urandom % 3);
      else f3 = ld_f3[$urandom % 5];
      dly = ($urandom % 8 == 0) ? 255 : $urandom % 4;
      issue(st, f3, 32'h1000 + ($urandom % 64), $urandom, dly);
    end

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    start(1'b0, 3'b010, 32'h100, 32'h0, 255);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("midreset_mem_req", 32'(mem_req), 32'd0);
    chk("midreset_resp_valid", 32'(resp_valid), 32'd0);
    chk("midreset_req_ready", 32'(req_ready), 32'd1);
    chk("midreset_resp_rdata", resp_rdata, 32'd0);
    resp_q.delete();
    mem_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1);
    repeat (3) @(negedge clk);
    chk("queues_drained", resp_q.size() + mem_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
